// File: rtl/oric_ram_bridge_if.sv
// oric_ram_bridge_if: CPU RAM bus and SDRAM port 1 signals of the bridge
interface oric_ram_bridge_if #(parameter int AW = 16);
  logic [AW-1:0] cpu_a;
  logic [7:0] cpu_d;
  logic [7:0] cpu_q;
  logic cpu_cs;
  logic cpu_oe;
  logic cpu_we;
  logic busy;
  logic req;
  logic ack;
  logic [AW-1:0] sd_a;
  logic sd_we;
  logic [1:0] sd_ds;
  logic [15:0] sd_d;
  logic [15:0] sd_q;
  logic timeout_err;
  logic [7:0] retry_cnt;
  modport slave (
    input cpu_a, cpu_d, cpu_cs, cpu_oe, cpu_we, ack, sd_q,
    output cpu_q, busy, req, sd_a, sd_we, sd_ds, sd_d, timeout_err, retry_cnt
  );
  modport master (
    output cpu_a, cpu_d, cpu_cs, cpu_oe, cpu_we, ack, sd_q,
    input cpu_q, busy, req, sd_a, sd_we, sd_ds, sd_d, timeout_err, retry_cnt
  );
endinterface

// File: rtl/oric_ram_bridge.sv
// oric_ram_bridge: Oric 8-bit RAM strobes to toggle-handshake SDRAM port with one-deep queue and ack watchdog
module oric_ram_bridge #(
  parameter int AW = 16,
  parameter int TIMEOUT = 63
) (
  input logic clk,
  input logic init_n,
  oric_ram_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, CANCEL} state_t;
  state_t state, state_nx;
  logic rd, wr, trig, done;
  logic rd_old, wr_old;
  logic [AW-1:0] a_old;
  logic pending, p_we;
  logic [AW-1:0] p_a;
  logic [7:0] p_d;
  logic [7:0] q_r;
  logic [9:0] cnt;
  logic issue, use_pend, cancel, reissue, to_pend, load_q;
  logic [AW-1:0] i_a;
  logic i_we;
  logic [7:0] i_d;
  assign rd = bus.cpu_cs & bus.cpu_oe;
  assign wr = bus.cpu_cs & bus.cpu_we;
  assign trig = (rd & ~rd_old) | (wr & ~wr_old) | (rd & (bus.cpu_a != a_old));
  assign done = bus.ack == bus.req;
  assign i_a = use_pend ? p_a : bus.cpu_a;
  assign i_we = use_pend ? p_we : bus.cpu_we;
  assign i_d = use_pend ? p_d : bus.cpu_d;
  assign bus.cpu_q = bus.cpu_cs ? q_r : 8'h00;
  assign bus.busy = (state != IDLE) | pending;
  // state register
  always_ff @(posedge clk)
    state <= !init_n ? IDLE : state_nx;
  // next state and per-edge actions; a fresh trigger on a completion edge beats the queued entry
  always_comb begin
    state_nx = state;
    issue = 1'b0;
    use_pend = 1'b0;
    cancel = 1'b0;
    reissue = 1'b0;
    to_pend = 1'b0;
    load_q = 1'b0;
    case (state)
      IDLE: begin
        issue = trig;
        state_nx = trig ? WAIT : IDLE;
      end
      WAIT:
        if (done) begin
          load_q = ~bus.sd_we;
          issue = trig | pending;
          use_pend = ~trig & pending;
          state_nx = (trig | pending) ? WAIT : IDLE;
        end else begin
          to_pend = trig;
          cancel = cnt == 10'(TIMEOUT - 1);
          state_nx = cancel ? CANCEL : WAIT;
        end
      default: begin
        reissue = 1'b1;
        to_pend = trig;
        state_nx = WAIT;
      end
    endcase
  end
  // datapath: edge history, request latch, queue slot, read capture, watchdog
  always_ff @(posedge clk)
    if (!init_n) begin
      rd_old <= 1'b0;
      wr_old <= 1'b0;
      a_old <= '0;
      bus.req <= 1'b0;
      bus.sd_a <= '0;
      bus.sd_we <= 1'b0;
      bus.sd_ds <= 2'b11;
      bus.sd_d <= 16'h0000;
      pending <= 1'b0;
      p_a <= '0;
      p_we <= 1'b0;
      p_d <= 8'h00;
      q_r <= 8'h00;
      cnt <= '0;
      bus.timeout_err <= 1'b0;
      bus.retry_cnt <= 8'h00;
    end else begin
      rd_old <= rd;
      wr_old <= wr;
      a_old <= bus.cpu_a;
      if (issue) begin
        bus.sd_a <= i_a;
        bus.sd_we <= i_we;
        bus.sd_ds <= i_we ? (i_a[0] ? 2'b10 : 2'b01) : 2'b11;
        bus.sd_d <= {i_d, i_d};
      end
      bus.req <= (issue | reissue) ? ~bus.req : cancel ? bus.ack : bus.req;
      if (to_pend) begin
        p_a <= bus.cpu_a;
        p_we <= bus.cpu_we;
        p_d <= bus.cpu_d;
      end
      pending <= issue ? 1'b0 : pending | to_pend;
      if (load_q)
        q_r <= bus.sd_a[0] ? bus.sd_q[15:8] : bus.sd_q[7:0];
      cnt <= (issue | reissue) ? '0 : state == WAIT ? cnt + 10'd1 : cnt;
      if (cancel) begin
        bus.timeout_err <= 1'b1;
        bus.retry_cnt <= bus.retry_cnt + {7'd0, bus.retry_cnt != 8'hFF};
      end
    end
endmodule

// File: tb/tb_oric_ram_bridge.sv
// tb_oric_ram_bridge: directed scenarios for the Oric RAM to SDRAM bridge
module tb_oric_ram_bridge;
  logic clk;
  logic init_n;
  int nvec;
  int nerr;
  int ntog;
  int n0;
  logic req_q;
  logic r1;
  oric_ram_bridge_if #(.AW(16)) bus ();
  oric_ram_bridge #(.AW(16), .TIMEOUT(8)) dut (.clk(clk), .init_n(init_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task tick;
    @(negedge clk);
    if (bus.req !== req_q) ntog++;
    req_q = bus.req;
  endtask
  task test_reset;
    init_n = 1'b0;
    bus.cpu_cs = 1'b1;
    tick;
    tick;
    nvec++;
    if ({bus.req, bus.sd_we, bus.sd_ds, bus.busy, bus.timeout_err} !== 6'b001100) begin
      nerr++;
      $display("FAIL reset_ctl: got %b want 001100", {bus.req, bus.sd_we, bus.sd_ds, bus.busy, bus.timeout_err});
    end
    nvec++;
    if ({bus.sd_a, bus.sd_d, bus.cpu_q, bus.retry_cnt} !== 48'h0) begin
      nerr++;
      $display("FAIL reset_data: got %h want 0", {bus.sd_a, bus.sd_d, bus.cpu_q, bus.retry_cnt});
    end
    init_n = 1'b1;
    tick;
  endtask
  task test_read;
    bus.cpu_a = 16'h1235;
    bus.cpu_oe = 1'b1;
    tick;
    nvec++;
    if ({bus.req, bus.sd_we, bus.sd_ds, bus.busy, bus.sd_a} !== {5'b10111, 16'h1235}) begin
      nerr++;
      $display("FAIL read_issue: got %h want %h", {bus.req, bus.sd_we, bus.sd_ds, bus.busy, bus.sd_a}, {5'b10111, 16'h1235});
    end
    repeat (4) tick;
    nvec++;
    if ({bus.busy, bus.cpu_q} !== 9'h100) begin
      nerr++;
      $display("FAIL read_wait: got %h want 100", {bus.busy, bus.cpu_q});
    end
    bus.sd_q = 16'hABCD;
    bus.ack = bus.req;
    tick;
    nvec++;
    if ({bus.busy, bus.cpu_q} !== 9'h0AB) begin
      nerr++;
      $display("FAIL read_done: got %h want 0ab", {bus.busy, bus.cpu_q});
    end
    tick;
    nvec++;
    if (bus.busy !== 1'b0) begin
      nerr++;
      $display("FAIL read_hold_noretrig: got %b want 0", bus.busy);
    end
    bus.cpu_cs = 1'b0;
    #1;
    nvec++;
    if (bus.cpu_q !== 8'h00) begin
      nerr++;
      $display("FAIL cs_gate: got %h want 00", bus.cpu_q);
    end
    bus.cpu_oe = 1'b0;
    tick;
    bus.cpu_cs = 1'b1;
    tick;
    nvec++;
    if ({bus.busy, bus.cpu_q} !== 9'h0AB) begin
      nerr++;
      $display("FAIL q_hold: got %h want 0ab", {bus.busy, bus.cpu_q});
    end
  endtask
  task test_write;
    bus.cpu_a = 16'h0400;
    bus.cpu_d = 8'h5A;
    bus.cpu_we = 1'b1;
    tick;
    nvec++;
    if ({bus.req, bus.sd_we, bus.sd_ds, bus.busy, bus.sd_a, bus.sd_d} !== {5'b01011, 16'h0400, 16'h5A5A}) begin
      nerr++;
      $display("FAIL write_issue: got %h want %h", {bus.req, bus.sd_we, bus.sd_ds, bus.busy, bus.sd_a, bus.sd_d}, {5'b01011, 16'h0400, 16'h5A5A});
    end
    bus.sd_q = 16'h1234;
    bus.ack = bus.req;
    tick;
    nvec++;
    if ({bus.busy, bus.cpu_q} !== 9'h0AB) begin
      nerr++;
      $display("FAIL write_no_q: got %h want 0ab", {bus.busy, bus.cpu_q});
    end
    bus.cpu_we = 1'b0;
    tick;
    bus.cpu_a = 16'h0401;
    bus.cpu_d = 8'hC3;
    bus.cpu_we = 1'b1;
    tick;
    nvec++;
    if ({bus.req, bus.sd_ds, bus.sd_d} !== {3'b110, 16'hC3C3}) begin
      nerr++;
      $display("FAIL write_odd: got %h want %h", {bus.req, bus.sd_ds, bus.sd_d}, {3'b110, 16'hC3C3});
    end
    bus.ack = bus.req;
    tick;
    bus.cpu_we = 1'b0;
    tick;
    nvec++;
    if ({bus.busy, bus.cpu_q} !== 9'h0AB) begin
      nerr++;
      $display("FAIL write_odd_done: got %h want 0ab", {bus.busy, bus.cpu_q});
    end
  endtask
  task test_addr_change;
    n0 = ntog;
    bus.cpu_a = 16'h2000;
    bus.cpu_oe = 1'b1;
    tick;
    bus.cpu_a = 16'h2001;
    tick;
    bus.cpu_a = 16'h2002;
    tick;
    nvec++;
    if ({bus.busy, bus.sd_a} !== {1'b1, 16'h2000}) begin
      nerr++;
      $display("FAIL addr_held: got %h want 12000", {bus.busy, bus.sd_a});
    end
    bus.sd_q = 16'h1111;
    bus.ack = bus.req;
    tick;
    nvec++;
    if ({bus.busy, bus.req ^ bus.ack, bus.sd_a} !== {2'b11, 16'h2002}) begin
      nerr++;
      $display("FAIL addr_pending: got %h want %h", {bus.busy, bus.req ^ bus.ack, bus.sd_a}, {2'b11, 16'h2002});
    end
    bus.sd_q = 16'h7755;
    bus.ack = bus.req;
    tick;
    nvec++;
    if ({bus.busy, bus.cpu_q} !== 9'h055) begin
      nerr++;
      $display("FAIL addr_done: got %h want 055", {bus.busy, bus.cpu_q});
    end
    nvec++;
    if (ntog - n0 !== 2) begin
      nerr++;
      $display("FAIL addr_txn_count: got %0d want 2", ntog - n0);
    end
    bus.cpu_oe = 1'b0;
    tick;
  endtask
  task test_back_to_back;
    n0 = ntog;
    bus.cpu_a = 16'h3001;
    bus.cpu_oe = 1'b1;
    tick;
    bus.cpu_oe = 1'b0;
    bus.cpu_we = 1'b1;
    bus.cpu_a = 16'h3100;
    bus.cpu_d = 8'h99;
    bus.sd_q = 16'hEE22;
    bus.ack = bus.req;
    tick;
    nvec++;
    if ({bus.cpu_q, bus.sd_we, bus.sd_ds, bus.sd_a, bus.sd_d} !== {8'hEE, 3'b101, 16'h3100, 16'h9999}) begin
      nerr++;
      $display("FAIL b2b_issue: got %h want %h", {bus.cpu_q, bus.sd_we, bus.sd_ds, bus.sd_a, bus.sd_d}, {8'hEE, 3'b101, 16'h3100, 16'h9999});
    end
    nvec++;
    if ({bus.busy, bus.req ^ bus.ack} !== 2'b11 || ntog - n0 !== 2) begin
      nerr++;
      $display("FAIL b2b_flight: got busy/pend %b toggles %0d want 11 2", {bus.busy, bus.req ^ bus.ack}, ntog - n0);
    end
    bus.ack = bus.req;
    tick;
    bus.cpu_we = 1'b0;
    tick;
    nvec++;
    if ({bus.busy, bus.cpu_q} !== 9'h0EE) begin
      nerr++;
      $display("FAIL b2b_done: got %h want 0ee", {bus.busy, bus.cpu_q});
    end
  endtask
  task test_timeout;
    bus.cpu_a = 16'h4444;
    bus.cpu_oe = 1'b1;
    tick;
    r1 = bus.req;
    repeat (7) tick;
    nvec++;
    if ({bus.req, bus.ack, bus.timeout_err, bus.retry_cnt} !== {r1, ~r1, 1'b0, 8'd0}) begin
      nerr++;
      $display("FAIL to_before: got %h want %h", {bus.req, bus.ack, bus.timeout_err, bus.retry_cnt}, {r1, ~r1, 1'b0, 8'd0});
    end
    tick;
    nvec++;
    if ({bus.req ^ bus.ack, bus.busy, bus.timeout_err, bus.retry_cnt} !== {3'b011, 8'd1}) begin
      nerr++;
      $display("FAIL to_cancel: got %h want %h", {bus.req ^ bus.ack, bus.busy, bus.timeout_err, bus.retry_cnt}, {3'b011, 8'd1});
    end
    tick;
    nvec++;
    if ({bus.req, bus.sd_we, bus.sd_ds, bus.sd_a} !== {r1, 3'b011, 16'h4444}) begin
      nerr++;
      $display("FAIL to_reissue: got %h want %h", {bus.req, bus.sd_we, bus.sd_ds, bus.sd_a}, {r1, 3'b011, 16'h4444});
    end
    bus.sd_q = 16'h5566;
    bus.ack = bus.req;
    tick;
    nvec++;
    if ({bus.busy, bus.cpu_q, bus.timeout_err, bus.retry_cnt} !== {1'b0, 8'h66, 1'b1, 8'd1}) begin
      nerr++;
      $display("FAIL to_done: got %h want %h", {bus.busy, bus.cpu_q, bus.timeout_err, bus.retry_cnt}, {1'b0, 8'h66, 1'b1, 8'd1});
    end
    bus.cpu_oe = 1'b0;
    tick;
  endtask
  task test_reset_mid;
    bus.cpu_a = 16'h5000;
    bus.cpu_oe = 1'b1;
    tick;
    nvec++;
    if (bus.busy !== 1'b1) begin
      nerr++;
      $display("FAIL mid_busy: got %b want 1", bus.busy);
    end
    init_n = 1'b0;
    bus.ack = 1'b0;
    bus.cpu_oe = 1'b0;
    tick;
    nvec++;
    if ({bus.req, bus.sd_we, bus.sd_ds, bus.busy, bus.timeout_err} !== 6'b001100) begin
      nerr++;
      $display("FAIL mid_reset_ctl: got %b want 001100", {bus.req, bus.sd_we, bus.sd_ds, bus.busy, bus.timeout_err});
    end
    nvec++;
    if ({bus.sd_a, bus.sd_d, bus.cpu_q, bus.retry_cnt} !== 48'h0) begin
      nerr++;
      $display("FAIL mid_reset_data: got %h want 0", {bus.sd_a, bus.sd_d, bus.cpu_q, bus.retry_cnt});
    end
    init_n = 1'b1;
    tick;
    nvec++;
    if (bus.busy !== 1'b0) begin
      nerr++;
      $display("FAIL mid_after: got %b want 0", bus.busy);
    end
  endtask
  initial begin
    nvec = 0;
    nerr = 0;
    ntog = 0;
    req_q = 1'b0;
    init_n = 1'b0;
    bus.cpu_a = 16'h0000;
    bus.cpu_d = 8'h00;
    bus.cpu_cs = 1'b0;
    bus.cpu_oe = 1'b0;
    bus.cpu_we = 1'b0;
    bus.ack = 1'b0;
    bus.sd_q = 16'h0000;
    test_reset;
    test_read;
    test_write;
    test_addr_change;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
